// File: rtl/thread_ctrl.sv
// thread_ctrl: validates thread-op requests and pulses commands to the per-thread
// status registers, and runs the round-robin time-slice scheduler that feeds fetch.
module thread_ctrl #(
  parameter int          NUM_TRD = 8,
  parameter int          SLICE   = 16,
  parameter logic [31:0] BOOT_PC = 32'h0000_0000,
  localparam int         TW      = $clog2(NUM_TRD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_vld,
  input  logic [1:0]         req_op,
  input  logic [TW-1:0]      req_trd,
  input  logic [31:0]        req_pc,
  output logic               req_rdy,
  output logic               rsp_vld,
  output logic               rsp_err,
  input  logic [NUM_TRD-1:0] trd_valid,
  input  logic [NUM_TRD-1:0] trd_running,
  input  logic [NUM_TRD-1:0] trd_err,
  output logic               init,
  output logic               slp,
  output logic               wake,
  output logic               kill,
  output logic [TW-1:0]      obj_trd,
  output logic [TW-1:0]      act_trd,
  output logic [31:0]        init_pc,
  output logic [TW-1:0]      cur_trd,
  output logic               trd_sw,
  output logic               all_idle
);

  localparam int            CW     = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SLICE - 1);

  typedef enum logic [1:0] {BOOT, IDLE, ISSUE, RESP} state_e;
  typedef enum logic [1:0] {OP_INIT, OP_SLEEP, OP_WAKE, OP_KILL} op_e;

  state_e        state;
  op_e           op;
  logic          reject;
  logic [TW-1:0] lat_trd;
  logic          lat_rej;
  logic [CW-1:0] cnt;
  logic          sw_due;
  logic          found;
  logic [TW-1:0] nxt_trd;
  logic [TW-1:0] idx;

  assign op       = op_e'(req_op);
  assign act_trd  = cur_trd;
  assign all_idle = ~|trd_running;

  // Init of an already-valid thread or wake of an invalid one never reaches the registers.
  assign reject = ((op == OP_INIT) &&  trd_valid[req_trd]) ||
                  ((op == OP_WAKE) && !trd_valid[req_trd]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      req_rdy <= 1'b0;
      rsp_vld <= 1'b0;
      rsp_err <= 1'b0;
      init    <= 1'b0;
      slp     <= 1'b0;
      wake    <= 1'b0;
      kill    <= 1'b0;
      obj_trd <= '0;
      init_pc <= '0;
      lat_trd <= '0;
      lat_rej <= 1'b0;
    end else begin
      init    <= 1'b0;
      slp     <= 1'b0;
      wake    <= 1'b0;
      kill    <= 1'b0;
      init_pc <= '0;
      rsp_vld <= 1'b0;
      rsp_err <= 1'b0;
      case (state)
        BOOT: begin
          // init doubles as the marker that the thread-0 boot pulse has gone out
          if (!init) begin
            init    <= 1'b1;
            obj_trd <= '0;
            init_pc <= BOOT_PC;
          end else begin
            state   <= IDLE;
            req_rdy <= 1'b1;
          end
        end
        IDLE: begin
          if (req_vld) begin
            state   <= ISSUE;
            req_rdy <= 1'b0;
            lat_trd <= req_trd;
            lat_rej <= reject;
            obj_trd <= req_trd;
            if (!reject) begin
              case (op)
                OP_INIT: begin
                  init    <= 1'b1;
                  init_pc <= req_pc;
                end
                OP_SLEEP: slp  <= 1'b1;
                OP_WAKE:  wake <= 1'b1;
                OP_KILL:  kill <= 1'b1;
                default:  ;
              endcase
            end
          end
        end
        ISSUE: begin
          state   <= RESP;
          rsp_vld <= 1'b1;
          rsp_err <= lat_rej | trd_err[lat_trd];
        end
        RESP: begin
          state   <= IDLE;
          req_rdy <= 1'b1;
        end
        default: state <= BOOT;
      endcase
    end
  end

  // Round-robin search starting after the current thread and wrapping back onto it.
  always_comb begin
    found   = 1'b0;
    nxt_trd = cur_trd;
    idx     = cur_trd;
    for (int i = 1; i <= NUM_TRD; i++) begin
      idx = TW'((int'(cur_trd) + i) % NUM_TRD);
      if (!found && trd_running[idx]) begin
        found   = 1'b1;
        nxt_trd = idx;
      end
    end
  end

  // Switching only in quiet IDLE cycles keeps every command on a single action thread.
  assign sw_due = (state == IDLE) && !req_vld &&
                  ((cnt == '0) || !trd_running[cur_trd]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= RELOAD;
      cur_trd <= '0;
      trd_sw  <= 1'b0;
    end else begin
      trd_sw <= 1'b0;
      if (sw_due && found) begin
        cnt <= RELOAD;
        if (nxt_trd != cur_trd) begin
          cur_trd <= nxt_trd;
          trd_sw  <= 1'b1;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_thread_ctrl.sv
// tb_thread_ctrl: directed scenarios plus a randomized run against a behavioural
// model of the request timeline and the round-robin slice scheduler.
module tb_thread_ctrl;

  localparam int          NUM_TRD = 8;
  localparam int          SLICE   = 16;
  localparam logic [31:0] BOOT_PC = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        req_vld;
  logic [1:0]  req_op;
  logic [2:0]  req_trd;
  logic [31:0] req_pc;
  logic        req_rdy;
  logic        rsp_vld;
  logic        rsp_err;
  logic [7:0]  trd_valid;
  logic [7:0]  trd_running;
  logic [7:0]  trd_err;
  logic        init;
  logic        slp;
  logic        wake;
  logic        kill;
  logic [2:0]  obj_trd;
  logic [2:0]  act_trd;
  logic [31:0] init_pc;
  logic [2:0]  cur_trd;
  logic        trd_sw;
  logic        all_idle;

  int checks;
  int errors;

  thread_ctrl #(.NUM_TRD(NUM_TRD), .SLICE(SLICE), .BOOT_PC(BOOT_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_op(req_op), .req_trd(req_trd), .req_pc(req_pc),
    .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_err(rsp_err),
    .trd_valid(trd_valid), .trd_running(trd_running), .trd_err(trd_err),
    .init(init), .slp(slp), .wake(wake), .kill(kill),
    .obj_trd(obj_trd), .act_trd(act_trd), .init_pc(init_pc),
    .cur_trd(cur_trd), .trd_sw(trd_sw), .all_idle(all_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: busy counts the cycles left before the controller is idle again,
  // left counts the cycles remaining in the current slice.
  int          m_busy;
  bit          m_inreq;
  logic [3:0]  m_cmd;
  logic [2:0]  m_obj;
  logic [31:0] m_pc;
  bit          m_rej;
  logic [2:0]  m_lat;
  bit          m_rsp;
  bit          m_rerr;
  logic [2:0]  m_cur;
  int          m_left;
  bit          m_sw;

  always @(posedge clk or negedge rst_n) begin : model
    int nxt;
    bit elig;
    bit rej;
    if (!rst_n) begin
      m_busy <= 2; m_inreq <= 0; m_cmd <= 0; m_obj <= 0; m_pc <= 0; m_rej <= 0;
      m_lat <= 0; m_rsp <= 0; m_rerr <= 0; m_cur <= 0; m_left <= SLICE - 1; m_sw <= 0;
    end else begin
      m_cmd <= 0; m_pc <= 0; m_rsp <= 0; m_rerr <= 0;
      if (m_busy == 2 && !m_inreq) begin
        m_cmd <= 4'b1000; m_obj <= 0; m_pc <= BOOT_PC; m_busy <= 1;
      end else if (m_busy == 2) begin
        m_rsp <= 1; m_rerr <= m_rej | trd_err[m_lat]; m_busy <= 1;
      end else if (m_busy == 1) begin
        m_busy <= 0; m_inreq <= 0;
      end else if (req_vld) begin
        rej = (req_op == 2'd0 && trd_valid[req_trd]) || (req_op == 2'd2 && !trd_valid[req_trd]);
        m_rej <= rej; m_lat <= req_trd; m_obj <= req_trd; m_inreq <= 1; m_busy <= 2;
        if (!rej) begin
          m_cmd <= 4'b1000 >> req_op;
          if (req_op == 2'd0) m_pc <= req_pc;
        end
      end
      elig = (m_busy == 0) && !req_vld && (m_left == 0 || !trd_running[m_cur]);
      nxt = -1;
      for (int k = 1; k <= NUM_TRD; k++)
        if (nxt < 0 && trd_running[(int'(m_cur) + k) % NUM_TRD]) nxt = (int'(m_cur) + k) % NUM_TRD;
      m_sw <= 0;
      if (elig && nxt >= 0) begin
        m_left <= SLICE - 1;
        if (nxt != int'(m_cur)) begin m_cur <= 3'(nxt); m_sw <= 1; end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end
    end
  end

  task automatic reset_dut(input logic [7:0] run, input logic [7:0] vld);
    @(negedge clk);
    rst_n = 0; req_vld = 0; trd_running = run; trd_valid = vld; trd_err = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic issue_req(input logic [1:0] op, input logic [2:0] trd, input logic [31:0] pc);
    int waitc = 0;
    while (req_rdy !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL req_rdy_timeout got %b want 1", req_rdy);
    end
    req_vld = 1; req_op = op; req_trd = trd; req_pc = pc;
    @(negedge clk);
    req_vld = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; req_vld = 0; req_op = 0; req_trd = 0; req_pc = 0;
    trd_running = 8'h01; trd_valid = 8'h01; trd_err = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({init, slp, wake, kill, obj_trd, act_trd, cur_trd, init_pc, req_rdy, rsp_vld, rsp_err, trd_sw} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h want 0",
               {init, slp, wake, kill, obj_trd, act_trd, cur_trd, init_pc, req_rdy, rsp_vld, rsp_err, trd_sw});
    end
    checks++;
    if (all_idle !== 1'b0) begin errors++; $display("[TB] FAIL all_idle_busy got %b want 0", all_idle); end
    trd_running = 8'h00;
    #1;
    checks++;
    if (all_idle !== 1'b1) begin errors++; $display("[TB] FAIL all_idle_clear got %b want 1", all_idle); end
    trd_running = 8'h01;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({init, slp, wake, kill} !== 4'b1000 || obj_trd !== 3'd0 || init_pc !== BOOT_PC) begin
      errors++;
      $display("[TB] FAIL boot_pulse got cmd=%b obj=%0d pc=%h want cmd=1000 obj=0 pc=%h",
               {init, slp, wake, kill}, obj_trd, init_pc, BOOT_PC);
    end
    checks++;
    if (req_rdy !== 1'b0 || rsp_vld !== 1'b0) begin
      errors++; $display("[TB] FAIL boot_rdy got rdy=%b rsp=%b want 0 0", req_rdy, rsp_vld);
    end
    @(negedge clk);
    checks++;
    if (req_rdy !== 1'b1 || cur_trd !== 3'd0 || init !== 1'b0) begin
      errors++;
      $display("[TB] FAIL boot_idle got rdy=%b cur=%0d init=%b want 1 0 0", req_rdy, cur_trd, init);
    end
  endtask

  task automatic test_init_ok();
    trd_valid = 8'h01; trd_err = 0;
    issue_req(2'd0, 3'd3, 32'h400);
    checks++;
    if ({init, slp, wake, kill} !== 4'b1000) begin
      errors++; $display("[TB] FAIL init_pulse got %b want 1000", {init, slp, wake, kill});
    end
    checks++;
    if (obj_trd !== 3'd3 || act_trd !== 3'd0) begin
      errors++; $display("[TB] FAIL init_ids got obj=%0d act=%0d want 3 0", obj_trd, act_trd);
    end
    checks++;
    if (init_pc !== 32'h400) begin errors++; $display("[TB] FAIL init_pc got %h want 400", init_pc); end
    @(negedge clk);
    checks++;
    if (rsp_vld !== 1'b1 || rsp_err !== 1'b0) begin
      errors++; $display("[TB] FAIL init_rsp got vld=%b err=%b want 1 0", rsp_vld, rsp_err);
    end
    checks++;
    if ({init, slp, wake, kill} !== 4'b0000) begin
      errors++; $display("[TB] FAIL init_pulse_width got %b want 0000", {init, slp, wake, kill});
    end
    @(negedge clk);
    checks++;
    if (req_rdy !== 1'b1 || rsp_vld !== 1'b0) begin
      errors++; $display("[TB] FAIL init_done got rdy=%b rsp=%b want 1 0", req_rdy, rsp_vld);
    end
  endtask

  task automatic test_reject();
    trd_valid = 8'h09; trd_err = 0;
    issue_req(2'd0, 3'd3, 32'h800);
    checks++;
    if ({init, slp, wake, kill} !== 4'b0000) begin
      errors++; $display("[TB] FAIL rej_init_pulse got %b want 0000", {init, slp, wake, kill});
    end
    @(negedge clk);
    checks++;
    if (rsp_vld !== 1'b1 || rsp_err !== 1'b1) begin
      errors++; $display("[TB] FAIL rej_init_rsp got vld=%b err=%b want 1 1", rsp_vld, rsp_err);
    end
    issue_req(2'd2, 3'd5, 32'h0);
    checks++;
    if ({init, slp, wake, kill} !== 4'b0000) begin
      errors++; $display("[TB] FAIL rej_wake_pulse got %b want 0000", {init, slp, wake, kill});
    end
    @(negedge clk);
    checks++;
    if (rsp_vld !== 1'b1 || rsp_err !== 1'b1) begin
      errors++; $display("[TB] FAIL rej_wake_rsp got vld=%b err=%b want 1 1", rsp_vld, rsp_err);
    end
    issue_req(2'd2, 3'd3, 32'h0);
    checks++;
    if ({init, slp, wake, kill} !== 4'b0010 || obj_trd !== 3'd3) begin
      errors++; $display("[TB] FAIL wake_ok got cmd=%b obj=%0d want 0010 3", {init, slp, wake, kill}, obj_trd);
    end
    @(negedge clk);
    checks++;
    if (rsp_vld !== 1'b1 || rsp_err !== 1'b0) begin
      errors++; $display("[TB] FAIL wake_ok_rsp got vld=%b err=%b want 1 0", rsp_vld, rsp_err);
    end
  endtask

  task automatic test_fault();
    trd_err = 8'h08;
    issue_req(2'd3, 3'd3, 32'h0);
    checks++;
    if ({init, slp, wake, kill} !== 4'b0001 || obj_trd !== 3'd3 || init_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL kill_pulse got cmd=%b obj=%0d pc=%h want 0001 3 0", {init, slp, wake, kill}, obj_trd, init_pc);
    end
    @(negedge clk);
    checks++;
    if (rsp_vld !== 1'b1 || rsp_err !== 1'b1) begin
      errors++; $display("[TB] FAIL kill_fault_rsp got vld=%b err=%b want 1 1", rsp_vld, rsp_err);
    end
    trd_err = 8'h00;
    issue_req(2'd1, 3'd3, 32'h0);
    checks++;
    if ({init, slp, wake, kill} !== 4'b0100) begin
      errors++; $display("[TB] FAIL sleep_pulse got %b want 0100", {init, slp, wake, kill});
    end
    @(negedge clk);
    checks++;
    if (rsp_vld !== 1'b1 || rsp_err !== 1'b0) begin
      errors++; $display("[TB] FAIL sleep_rsp got vld=%b err=%b want 1 0", rsp_vld, rsp_err);
    end
  endtask

  task automatic test_rr();
    int sw1 = -1;
    int sw2 = -1;
    logic [2:0] c1 = 3'd7;
    logic [2:0] c2 = 3'd7;
    reset_dut(8'h09, 8'h09);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (trd_sw === 1'b1) begin
        if (sw1 < 0) begin sw1 = n; c1 = cur_trd; end
        else if (sw2 < 0) begin sw2 = n; c2 = cur_trd; end
      end
    end
    checks++;
    if (sw1 != 16 || c1 !== 3'd3) begin
      errors++; $display("[TB] FAIL rr_first got cycle=%0d cur=%0d want 16 3", sw1, c1);
    end
    checks++;
    if (sw2 != 32 || c2 !== 3'd0) begin
      errors++; $display("[TB] FAIL rr_second got cycle=%0d cur=%0d want 32 0", sw2, c2);
    end
  endtask

  task automatic test_single();
    int nsw = 0;
    reset_dut(8'h01, 8'h01);
    repeat (40) begin
      @(negedge clk);
      if (trd_sw === 1'b1) nsw++;
    end
    checks++;
    if (nsw != 0 || cur_trd !== 3'd0) begin
      errors++; $display("[TB] FAIL single_thread got sw=%0d cur=%0d want 0 0", nsw, cur_trd);
    end
  endtask

  task automatic test_drop();
    int nsw = 0;
    reset_dut(8'h09, 8'h09);
    repeat (5) @(negedge clk);
    trd_running = 8'h08;
    @(negedge clk);
    checks++;
    if (trd_sw !== 1'b1 || cur_trd !== 3'd3) begin
      errors++; $display("[TB] FAIL drop_switch got sw=%b cur=%0d want 1 3", trd_sw, cur_trd);
    end
    trd_running = 8'h00;
    #1;
    checks++;
    if (all_idle !== 1'b1) begin errors++; $display("[TB] FAIL drop_all_idle got %b want 1", all_idle); end
    repeat (20) begin
      @(negedge clk);
      if (trd_sw === 1'b1) nsw++;
    end
    checks++;
    if (nsw != 0 || cur_trd !== 3'd3) begin
      errors++; $display("[TB] FAIL idle_hold got sw=%0d cur=%0d want 0 3", nsw, cur_trd);
    end
  endtask

  task automatic test_defer();
    for (int acc = 15; acc <= 16; acc++) begin
      int sw_at = -1;
      reset_dut(8'h09, 8'h01);
      for (int n = 1; n <= 25; n++) begin
        @(negedge clk);
        if (trd_sw === 1'b1 && sw_at < 0) sw_at = n;
        if (n == acc) begin
          checks++;
          if (slp !== 1'b1 || act_trd !== 3'd0) begin
            errors++; $display("[TB] FAIL defer_issue acc=%0d got slp=%b act=%0d want 1 0", acc, slp, act_trd);
          end
        end
        if (n == acc + 1) begin
          checks++;
          if (rsp_vld !== 1'b1 || cur_trd !== 3'd0) begin
            errors++; $display("[TB] FAIL defer_resp acc=%0d got rsp=%b cur=%0d want 1 0", acc, rsp_vld, cur_trd);
          end
        end
        req_vld = (n == acc - 1);
        req_op = 2'd1; req_trd = 3'd2; req_pc = 0;
      end
      checks++;
      if (sw_at != acc + 3) begin
        errors++; $display("[TB] FAIL defer_switch acc=%0d got cycle=%0d want %0d", acc, sw_at, acc + 3);
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    reset_dut(8'h01, 8'h01);
    repeat (2) @(negedge clk);
    issue_req(2'd1, 3'd4, 32'h0);
    checks++;
    if (slp !== 1'b1) begin errors++; $display("[TB] FAIL mid_issue_pulse got %b want 1", slp); end
    rst_n = 0;
    #1;
    checks++;
    if ({init, slp, wake, kill, obj_trd, act_trd, cur_trd, init_pc, req_rdy, rsp_vld, rsp_err, trd_sw} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs got %h want 0",
               {init, slp, wake, kill, obj_trd, act_trd, cur_trd, init_pc, req_rdy, rsp_vld, rsp_err, trd_sw});
    end
    @(negedge clk);
    checks++;
    if (rsp_vld !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_rsp got %b want 0", rsp_vld); end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (init !== 1'b1 || rsp_vld !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reboot got init=%b rsp=%b want 1 0", init, rsp_vld);
    end
    @(negedge clk);
    checks++;
    if (req_rdy !== 1'b1 || rsp_vld !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reboot_idle got rdy=%b rsp=%b want 1 0", req_rdy, rsp_vld);
    end
  endtask

  task automatic test_random();
    reset_dut(8'($urandom), 8'($urandom));
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      checks++;
      if (req_rdy !== (m_busy == 0)) begin
        errors++; $display("[TB] FAIL rnd_rdy cyc=%0d got %b want %b", n, req_rdy, m_busy == 0);
      end
      checks++;
      if ({init, slp, wake, kill} !== m_cmd || init_pc !== m_pc) begin
        errors++;
        $display("[TB] FAIL rnd_cmd cyc=%0d got %b/%h want %b/%h", n, {init, slp, wake, kill}, init_pc, m_cmd, m_pc);
      end
      if (m_cmd != 4'b0000) begin
        checks++;
        if (obj_trd !== m_obj) begin errors++; $display("[TB] FAIL rnd_obj cyc=%0d got %0d want %0d", n, obj_trd, m_obj); end
      end
      checks++;
      if (rsp_vld !== m_rsp || rsp_err !== m_rerr) begin
        errors++; $display("[TB] FAIL rnd_rsp cyc=%0d got %b%b want %b%b", n, rsp_vld, rsp_err, m_rsp, m_rerr);
      end
      checks++;
      if (cur_trd !== m_cur || act_trd !== m_cur || trd_sw !== m_sw) begin
        errors++;
        $display("[TB] FAIL rnd_sched cyc=%0d got cur=%0d act=%0d sw=%b want %0d %0d %b",
                 n, cur_trd, act_trd, trd_sw, m_cur, m_cur, m_sw);
      end
      checks++;
      if (all_idle !== (trd_running == 8'h00)) begin
        errors++; $display("[TB] FAIL rnd_all_idle cyc=%0d got %b want %b", n, all_idle, trd_running == 8'h00);
      end
      if ($urandom_range(0, 7) == 0) trd_running = trd_running ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) trd_running = 8'($urandom_range(0, 255));
      trd_err = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      req_vld = ($urandom_range(0, 3) == 0);
      req_op  = 2'($urandom_range(0, 3));
      req_trd = 3'($urandom_range(0, 7));
      req_pc  = $urandom;
    end
    req_vld = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 0;
    req_vld = 0; req_op = 0; req_trd = 0; req_pc = 0;
    trd_valid = 0; trd_running = 0; trd_err = 0;
    test_reset();
    test_init_ok();
    test_reject();
    test_fault();
    test_rr();
    test_single();
    test_drop();
    test_defer();
    test_reset_mid_issue();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thread_ctrl.md
# thread_ctrl

Central thread-management controller that drives the command side of the per-thread status registers. It accepts thread-operation requests (spawn, sleep, wake, kill) from the execute stage and validates them against per-thread status. It broadcasts single-cycle command pulses with objective and action thread IDs, and reports completion. It also runs a round-robin time-slice scheduler that selects the current (action) thread for fetch.

## Interface
- NUM_TRD, 8, number of hardware threads (IDs 3 bits wide)
- SLICE, 16, time-slice length in cycles (≥2)
- BOOT_PC, 32'h0000_0000, start PC of thread 0 after reset

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_vld  in  1  thread-op request valid
- req_op  in  2  00 init, 01 sleep, 10 wake, 11 kill
- req_trd  in  3  target thread ID
- req_pc  in  32  start PC (init only)
- req_rdy  out  1  controller can accept a request
- rsp_vld  out  1  one-cycle completion pulse
- rsp_err  out  1  request rejected/faulted; valid with rsp_vld
- trd_valid  in  NUM_TRD  per-thread valid from status registers
- trd_running  in  NUM_TRD  per-thread running
- trd_err  in  NUM_TRD  per-thread combinational error
- init, slp, wake, kill  out  1 each  command pulses
- obj_trd  out  3  objective thread of command
- act_trd  out  3  action thread; always equals cur_trd
- init_pc  out  32  start PC accompanying init
- cur_trd  out  3  currently scheduled thread
- trd_sw  out  1  one-cycle pulse when cur_trd changes
- all_idle  out  1  combinational ~|trd_running

## Operation
- FSM states: BOOT, IDLE, ISSUE, RESP. Reset state is BOOT.
- BOOT (exactly one cycle after reset release): init=1, obj_trd=0, init_pc=BOOT_PC; next state IDLE; no rsp_vld.
- IDLE: req_rdy=1. If req_vld, latch op/trd/pc and go to ISSUE.
- ISSUE: pre-check the latched op.
  - init to a thread with trd_valid=1 → reject, no pulse.
  - wake to a thread with trd_valid=0 → reject, no pulse.
  - Otherwise assert exactly one of init/slp/wake/kill with obj_trd=latched trd and init_pc=latched pc (init_pc=0 for non-init ops).
  - Sample trd_err[obj_trd] in the same cycle; a 1 marks the request as faulted.
  - Next state RESP.
- RESP: rsp_vld=1; rsp_err = rejected | faulted; next state IDLE.
- Command outputs are decoded from state and latched op only, never from live req_* inputs.
- Scheduler slice counter:
  - cnt reloads to SLICE-1 on reset and on every switch.
  - Otherwise it decrements each cycle, saturating at 0.
- Switch condition is (cnt==0 | ~trd_running[cur_trd]), evaluated only in IDLE cycles with no request acceptance. While blocked, cnt holds at 0 and the pending switch fires on the first eligible cycle.
- Next thread: first index with trd_running set, searched from cur_trd+1 and wrapping modulo NUM_TRD back to cur_trd.
  - If the found thread ≠ cur_trd: update cur_trd, pulse trd_sw, reload cnt.
  - If only cur_trd is running: reload cnt, no trd_sw.
  - If no thread is running: cur_trd holds, no trd_sw, cnt stays 0.

## Timing
- Reset values: init=slp=wake=kill=0, obj_trd=0, act_trd=cur_trd=0, init_pc=0, req_rdy=0, rsp_vld=0, rsp_err=0, trd_sw=0, cnt=SLICE-1. all_idle follows its inputs.
- Request latency: accept at edge N → command pulse in cycle N+1 → rsp_vld in cycle N+2.
- req_rdy is low for 2 cycles after each accept. Maximum throughput is one request per 3 cycles.
- act_trd/cur_trd is stable from accept through RESP; a command never straddles a thread switch.
- cur_trd updates at the edge ending the switch-eligible cycle; trd_sw is high the following cycle only.
- Reset mid-operation: any pending request is dropped with no rsp_vld, and the FSM restarts at BOOT.
- When req_vld and a switch become eligible in the same IDLE cycle, the request wins and the switch defers.

## Test plan
- Reset release → cycle 1: init=1, obj_trd=0, init_pc=BOOT_PC. Cycle 2: req_rdy=1, cur_trd=0.
- Thread 0 running, req init trd 3 pc 0x400 → next cycle init=1, obj_trd=3, act_trd=0, init_pc=0x400 → then rsp_vld=1, rsp_err=0.
- Init to trd 3 with trd_valid[3]=1 → no command pulse; rsp_vld=1, rsp_err=1. Also: kill trd 3 with trd_err[3]=1 in ISSUE → kill pulses, rsp_err=1.
- trd_running=8'b0000_1001, SLICE=16 → cur_trd 0→3 after 16 cycles, 3→0 after another 16, trd_sw pulses each time. With 8'b0000_0001 → no trd_sw, cur_trd stays 0.
- Clear trd_running[cur_trd] mid-slice → switch on next eligible IDLE cycle. All bits clear → all_idle=1, cur_trd held.
- Slice expires while FSM in ISSUE → switch deferred until IDLE. Assert rst_n low during ISSUE → all outputs at reset values, no rsp_vld.
